ppu_line_compositor: RTL and testbench

Downstream pixel stage of the PPU. It takes the per-line background and sprite buffers assembled by the fetch stage during hsync, double-buffers them, and serialises them into 24-bit RGB pixels in step with the VGA counters. It resolves sprite-over-background priority and transparency, and drives the VGA colour outputs.

---
 rtl/ppu_line_compositor.sv | 147 ++++++++++++++
 tb/tb_ppu_line_compositor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ppu_line_compositor.sv
// Line compositor: double-buffers the fetch stage's line buffers and serialises
// them into RGB pixels, resolving sprite priority and transparency.
module ppu_line_compositor #(
  parameter int NUM_SPRITES = 3,
  parameter int ACTIVE_W    = 640,
  parameter int ACTIVE_H    = 480
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [10:0]               hcount,
  input  logic [9:0]                vcount,
  input  logic                      line_load,
  input  logic [1279:0]             bg_graphics,
  input  logic [39:0]               bg_palette,
  input  logic [NUM_SPRITES*32-1:0] spr_graphics,
  input  logic [NUM_SPRITES*16-1:0] spr_x,
  input  logic [NUM_SPRITES-1:0]    spr_palette,
  input  logic [NUM_SPRITES-1:0]    spr_valid,
  input  logic [191:0]              palettes,
  output logic [7:0]                VGA_R,
  output logic [7:0]                VGA_G,
  output logic [7:0]                VGA_B,
  output logic                      pixel_valid
);

  localparam logic [9:0] ACTIVE_W_L = 10'(ACTIVE_W);
  localparam logic [9:0] ACTIVE_H_L = 10'(ACTIVE_H);

  typedef struct packed {
    logic [1279:0]             bg_graphics;
    logic [39:0]               bg_palette;
    logic [NUM_SPRITES*32-1:0] spr_graphics;
    logic [NUM_SPRITES*16-1:0] spr_x;
    logic [NUM_SPRITES-1:0]    spr_palette;
    logic [NUM_SPRITES-1:0]    spr_valid;
    logic [191:0]              palettes;
  } line_t;

  typedef enum logic [1:0] {EMPTY, LOADED, RUN} state_t;

  line_t  line_in, shadow, front, front_eff;
  state_t state, state_next;
  logic   pending, swap, front_valid, eff_valid;

  assign line_in = {bg_graphics, bg_palette, spr_graphics, spr_x,
                    spr_palette, spr_valid, palettes};

  assign swap        = (hcount == 11'd0) && (pending || line_load);
  assign front_valid = (state == RUN);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process order.
  // NOTE: the line buffers are reset too, so a reset mid-frame never exposes
  // stale or X data once a line is swapped in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      front   <= '0;
      pending <= 1'b0;
    end else begin
      if (line_load) shadow <= line_in;
      if (swap) front <= line_load ? line_in : shadow;
      if (hcount == 11'd0) pending <= 1'b0;
      else if (line_load)  pending <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      EMPTY:   if (swap) state_next = RUN;
               else if (line_load) state_next = LOADED;
      LOADED:  if (swap) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = EMPTY;
    endcase
  end

  // Stage 1 sees the post-swap line on hcount==0, so pixel 0 of a fresh line is correct.
  assign front_eff = swap ? (line_load ? line_in : shadow) : front;
  assign eff_valid = front_valid || swap;

  logic [9:0]  x;
  logic        in_w, vis;
  logic [5:0]  tile;
  logic [1:0]  bg_px, spr_px;
  logic [16:0] diff;
  logic        spr_found;
  logic [2:0]  spr_idx, index;

  always_comb begin
    x         = hcount[10:1];
    in_w      = (x < ACTIVE_W_L);
    vis       = eff_valid && in_w && (vcount < ACTIVE_H_L);
    tile      = in_w ? x[9:4] : 6'd0;
    bg_px     = front_eff.bg_graphics[{tile, x[3:0], 1'b0} +: 2];
    diff      = '0;
    spr_px    = '0;
    spr_found = 1'b0;
    spr_idx   = '0;
    // Walk slots from 0 up; the first opaque hit keeps priority.
    for (int s = 0; s < NUM_SPRITES; s++) begin
      diff   = {7'd0, x} - {1'b0, front_eff.spr_x[s*16 +: 16]};
      spr_px = front_eff.spr_graphics[s*32 + 2*diff[3:0] +: 2];
      if (!spr_found && front_eff.spr_valid[s] && !diff[16] &&
          (diff[15:4] == 12'd0) && (spr_px != 2'd0)) begin
        spr_found = 1'b1;
        spr_idx   = {front_eff.spr_palette[s], spr_px};
      end
    end
    index = spr_found ? spr_idx : {front_eff.bg_palette[tile], bg_px};
  end

  logic [2:0] s1_index;
  logic       s1_visible, s1_fresh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_index   <= '0;
      s1_visible <= 1'b0;
      s1_fresh   <= 1'b0;
    end else begin
      s1_fresh <= ~hcount[0];
      if (!hcount[0]) begin
        s1_index   <= index;
        s1_visible <= vis;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {VGA_R, VGA_G, VGA_B} <= '0;
      pixel_valid           <= 1'b0;
    end else if (s1_fresh) begin
      {VGA_R, VGA_G, VGA_B} <= s1_visible ? front.palettes[s1_index*24 +: 24] : 24'd0;
      pixel_valid           <= s1_visible;
    end
  end

endmodule

// File: tb/tb_ppu_line_compositor.sv
// Directed bench for ppu_line_compositor: drives hcount/vcount line by line,
// captures every output cycle, then checks pixel ranges against hand values.
module tb_ppu_line_compositor;
  localparam int NS = 3;
  localparam logic [23:0] C0 = 24'h112233, C1 = 24'h445566, C2 = 24'h778899,
                          C3 = 24'hAABBCC, C4 = 24'hC04040, C5 = 24'hC05050,
                          C6 = 24'hC06060, C7 = 24'hC07070;

  logic            clk = 1'b0;
  logic            reset;
  logic [10:0]     hcount;
  logic [9:0]      vcount;
  logic            line_load;
  logic [1279:0]   bg_graphics;
  logic [39:0]     bg_palette;
  logic [NS*32-1:0] spr_graphics;
  logic [NS*16-1:0] spr_x;
  logic [NS-1:0]   spr_palette;
  logic [NS-1:0]   spr_valid;
  logic [191:0]    palettes;
  logic [7:0]      VGA_R, VGA_G, VGA_B;
  logic            pixel_valid;

  int checks   = 0;
  int failures = 0;
  logic [23:0] pal [8];
  logic [24:0] cap [0:1299];
  logic [24:0] pre [0:1];

  ppu_line_compositor #(.NUM_SPRITES(NS), .ACTIVE_W(640), .ACTIVE_H(480)) dut (
    .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .line_load(line_load), .bg_graphics(bg_graphics), .bg_palette(bg_palette),
    .spr_graphics(spr_graphics), .spr_x(spr_x), .spr_palette(spr_palette),
    .spr_valid(spr_valid), .palettes(palettes),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B), .pixel_valid(pixel_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [24:0] got, input logic [24:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic apply_pal();
    for (int i = 0; i < 8; i++) palettes[i*24 +: 24] = pal[i];
  endtask

  task automatic clear_data();
    bg_graphics  = '0;
    bg_palette   = '0;
    spr_graphics = '0;
    spr_x        = '0;
    spr_palette  = '0;
    spr_valid    = '0;
    pal[0] = C0; pal[1] = C1; pal[2] = C2; pal[3] = C3;
    pal[4] = C4; pal[5] = C5; pal[6] = C6; pal[7] = C7;
    apply_pal();
  endtask

  // Drives hcount h_lo..h_hi on line vc; cap[k] holds the output seen while hcount k+2 is set up.
  task automatic run_line(input int vc, input int h_lo, input int h_hi,
                          input int load_at, input int reset_at);
    vcount = vc[9:0];
    for (int h = h_lo; h <= h_hi; h++) begin
      @(negedge clk);
      if (h >= 2) cap[h-2] = {pixel_valid, VGA_R, VGA_G, VGA_B};
      else        pre[h]   = {pixel_valid, VGA_R, VGA_G, VGA_B};
      hcount    = h[10:0];
      line_load = (h == load_at);
      reset     = (h == reset_at);
      if (h == reset_at) begin
        #1;
        chk("reset_async", {pixel_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
      end
    end
  endtask

  task automatic check_range(input string tag, input int x0, input int x1,
                             input logic [23:0] rgb, input logic vld);
    logic [24:0] exp;
    logic [24:0] got;
    exp = {vld, rgb};
    got = cap[2*x0];
    for (int k = 2*x0; k <= 2*x1 + 1; k++) begin
      if (cap[k] !== exp) begin
        got = cap[k];
        break;
      end
    end
    chk(tag, got, exp);
  endtask

  initial begin
    reset = 1'b1; hcount = '0; vcount = '0; line_load = 1'b0;
    clear_data();
    repeat (3) @(negedge clk);
    chk("reset_out", {pixel_valid, VGA_R, VGA_G, VGA_B}, 25'd0);
    reset = 1'b0;

    run_line(0, 0, 1299, -1, -1);
    check_range("empty_dark", 0, 648, 24'd0, 1'b0);

    // Load all-zero data; the line carrying the load stays dark.
    run_line(1, 0, 1299, 5, -1);
    check_range("loaded_dark", 0, 648, 24'd0, 1'b0);

    // Next data presented now, loaded mid-line 2; line 2 shows the first load.
    bg_graphics[32 +: 32] = 32'hE4E4E4E4;
    bg_palette[1]         = 1'b1;
    spr_valid             = 3'b111;
    spr_x                 = {16'd630, 16'd650, 16'd100};
    spr_graphics          = {32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000003};
    spr_palette           = 3'b110;
    run_line(2, 0, 1299, 100, -1);
    chk("first_px_h0", pre[0], 25'd0);
    chk("first_px_h1", pre[1], 25'd0);
    check_range("bg0_full_line", 0, 639, C0, 1'b1);
    check_range("blank_right", 640, 648, 24'd0, 1'b0);

    run_line(3, 0, 1299, -1, -1);
    check_range("tile0_no_wrap", 0, 15, C0, 1'b1);
    check_range("bg_x16", 16, 16, C4, 1'b1);
    check_range("bg_x17", 17, 17, C5, 1'b1);
    check_range("bg_x18", 18, 18, C6, 1'b1);
    check_range("bg_x19", 19, 19, C7, 1'b1);
    check_range("bg_x28", 28, 28, C4, 1'b1);
    check_range("bg_x31", 31, 31, C7, 1'b1);
    check_range("bg_32_99", 32, 99, C0, 1'b1);
    check_range("spr_px0", 100, 100, C3, 1'b1);
    check_range("spr_transp", 101, 115, C0, 1'b1);
    check_range("bg_116_629", 116, 629, C0, 1'b1);
    check_range("spr_right_edge", 630, 639, C7, 1'b1);
    check_range("spr_no_draw_blank", 640, 648, 24'd0, 1'b0);

    // Priority data loaded on hcount==0: shows on this very line.
    clear_data();
    spr_valid    = 3'b011;
    spr_x        = {16'd0, 16'd200, 16'd200};
    spr_graphics = {32'hFFFFFFFF, 32'h0000000E, 32'h00000001};
    spr_palette  = 3'b110;
    run_line(4, 0, 1299, 0, -1);
    check_range("invalid_slot_hidden", 0, 15, C0, 1'b1);
    check_range("slot0_wins", 200, 200, C1, 1'b1);
    check_range("slot1_under_transp", 201, 201, C7, 1'b1);
    check_range("after_sprites", 202, 215, C0, 1'b1);

    // Two loads within line 5; only the second reaches line 6.
    clear_data();
    pal[0] = 24'h0A0A0A;
    apply_pal();
    run_line(5, 0, 599, 300, -1);
    clear_data();
    pal[0] = 24'h0B0B0B;
    apply_pal();
    spr_valid           = 3'b001;
    spr_x[15:0]         = 16'd100;
    spr_graphics[31:0]  = 32'h00000003;
    spr_palette         = 3'b001;
    run_line(5, 600, 1299, 900, -1);
    check_range("midload_unchanged", 0, 199, C0, 1'b1);
    check_range("midload_slot0", 200, 200, C1, 1'b1);

    run_line(6, 0, 1299, -1, -1);
    check_range("second_load_bg", 0, 99, 24'h0B0B0B, 1'b1);
    check_range("spr_pal1", 100, 100, C7, 1'b1);
    check_range("second_load_tail", 101, 639, 24'h0B0B0B, 1'b1);

    run_line(480, 0, 1299, -1, -1);
    check_range("vblank_dark", 0, 648, 24'd0, 1'b0);

    // No load: line 7 repeats line 6 until reset at x=300.
    run_line(7, 0, 1299, -1, 600);
    check_range("repeat_pre_reset", 101, 298, 24'h0B0B0B, 1'b1);
    check_range("post_reset_dark", 300, 648, 24'd0, 1'b0);

    run_line(8, 0, 1299, 10, -1);
    check_range("after_reset_loaded_dark", 0, 648, 24'd0, 1'b0);

    run_line(9, 0, 1299, -1, -1);
    check_range("after_reset_swap", 0, 99, 24'h0B0B0B, 1'b1);
    check_range("after_reset_spr", 100, 100, C7, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
